// File: rtl/md5_compress.sv
// md5_compress: iterative MD5 compression function, one step per clock.
//   A start accepted in IDLE latches the block and chaining value. 64 RUN
//   cycles then execute steps 0..63, and a FIN cycle adds the chaining value
//   into the working state and pulses done.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               compress request (sampled in IDLE only)
//   block_in[511:0]     message words Mk = block_in[32k+31:32k]
//   chain_in[127:0]     {A,B,C,D} chaining value (only with MD5_CHAIN_IN_EN)
//   busy                high while a block is in flight
//   done                one-cycle pulse, digest_out valid
//   digest_out[127:0]   {A,B,C,D} result, held until the next done
// Configuration macro: MD5_CHAIN_IN_EN adds chain_in. When it is undefined,
//   the chaining value is the fixed MD5 IV.
module md5_compress (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] block_in,
`ifdef MD5_CHAIN_IN_EN
    input  logic [127:0] chain_in,
`endif
    output logic         busy,
    output logic         done,
    output logic [127:0] digest_out
);
    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state_q;
    logic [5:0]    i_q;
    logic [511:0]  blk_q;
    logic [127:0]  chain_q, dig_q;
    logic [31:0]   a_q, b_q, c_q, d_q;
    logic          busy_q, done_q;

    logic [127:0]  chain_src;
`ifdef MD5_CHAIN_IN_EN
    assign chain_src = chain_in;
`else
    assign chain_src = IV;
`endif

    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] n);
        // n is never 0 here, so the right shift stays below 32
        return (v << n) | (v >> (6'd32 - {1'b0, n}));
    endfunction

    logic [1:0]  rnd;
    logic [3:0]  il, g_d;
    logic [4:0]  s_d;
    logic [31:0] f_d, t_d, x_d, b_d;

    assign rnd = i_q[5:4];
    assign il  = i_q[3:0];

    always_comb begin
        f_d = 32'h0;
        g_d = 4'h0;
        case (rnd)
            2'd0: begin f_d = (b_q & c_q) | (~b_q & d_q); g_d = il;                 end
            2'd1: begin f_d = (b_q & d_q) | (c_q & ~d_q); g_d = il * 4'd5 + 4'd1;   end
            2'd2: begin f_d = b_q ^ c_q ^ d_q;            g_d = il * 4'd3 + 4'd5;   end
            default: begin f_d = c_q ^ (b_q | ~d_q);      g_d = il * 4'd7;          end
        endcase
    end

    always_comb begin
        s_d = 5'd0;
        case ({rnd, i_q[1:0]})
            4'h0: s_d = 5'd7;  4'h1: s_d = 5'd12; 4'h2: s_d = 5'd17; 4'h3: s_d = 5'd22;
            4'h4: s_d = 5'd5;  4'h5: s_d = 5'd9;  4'h6: s_d = 5'd14; 4'h7: s_d = 5'd20;
            4'h8: s_d = 5'd4;  4'h9: s_d = 5'd11; 4'ha: s_d = 5'd16; 4'hb: s_d = 5'd23;
            4'hc: s_d = 5'd6;  4'hd: s_d = 5'd10; 4'he: s_d = 5'd15; default: s_d = 5'd21;
        endcase
    end

    // floor(2^32 * |sin(i+1)|)
    always_comb begin
        t_d = 32'h0;
        case (i_q)
            6'd0:  t_d = 32'hd76aa478; 6'd1:  t_d = 32'he8c7b756; 6'd2:  t_d = 32'h242070db; 6'd3:  t_d = 32'hc1bdceee;
            6'd4:  t_d = 32'hf57c0faf; 6'd5:  t_d = 32'h4787c62a; 6'd6:  t_d = 32'ha8304613; 6'd7:  t_d = 32'hfd469501;
            6'd8:  t_d = 32'h698098d8; 6'd9:  t_d = 32'h8b44f7af; 6'd10: t_d = 32'hffff5bb1; 6'd11: t_d = 32'h895cd7be;
            6'd12: t_d = 32'h6b901122; 6'd13: t_d = 32'hfd987193; 6'd14: t_d = 32'ha679438e; 6'd15: t_d = 32'h49b40821;
            6'd16: t_d = 32'hf61e2562; 6'd17: t_d = 32'hc040b340; 6'd18: t_d = 32'h265e5a51; 6'd19: t_d = 32'he9b6c7aa;
            6'd20: t_d = 32'hd62f105d; 6'd21: t_d = 32'h02441453; 6'd22: t_d = 32'hd8a1e681; 6'd23: t_d = 32'he7d3fbc8;
            6'd24: t_d = 32'h21e1cde6; 6'd25: t_d = 32'hc33707d6; 6'd26: t_d = 32'hf4d50d87; 6'd27: t_d = 32'h455a14ed;
            6'd28: t_d = 32'ha9e3e905; 6'd29: t_d = 32'hfcefa3f8; 6'd30: t_d = 32'h676f02d9; 6'd31: t_d = 32'h8d2a4c8a;
            6'd32: t_d = 32'hfffa3942; 6'd33: t_d = 32'h8771f681; 6'd34: t_d = 32'h6d9d6122; 6'd35: t_d = 32'hfde5380c;
            6'd36: t_d = 32'ha4beea44; 6'd37: t_d = 32'h4bdecfa9; 6'd38: t_d = 32'hf6bb4b60; 6'd39: t_d = 32'hbebfbc70;
            6'd40: t_d = 32'h289b7ec6; 6'd41: t_d = 32'heaa127fa; 6'd42: t_d = 32'hd4ef3085; 6'd43: t_d = 32'h04881d05;
            6'd44: t_d = 32'hd9d4d039; 6'd45: t_d = 32'he6db99e5; 6'd46: t_d = 32'h1fa27cf8; 6'd47: t_d = 32'hc4ac5665;
            6'd48: t_d = 32'hf4292244; 6'd49: t_d = 32'h432aff97; 6'd50: t_d = 32'hab9423a7; 6'd51: t_d = 32'hfc93a039;
            6'd52: t_d = 32'h655b59c3; 6'd53: t_d = 32'h8f0ccc92; 6'd54: t_d = 32'hffeff47d; 6'd55: t_d = 32'h85845dd1;
            6'd56: t_d = 32'h6fa87e4f; 6'd57: t_d = 32'hfe2ce6e0; 6'd58: t_d = 32'ha3014314; 6'd59: t_d = 32'h4e0811a1;
            6'd60: t_d = 32'hf7537e82; 6'd61: t_d = 32'hbd3af235; 6'd62: t_d = 32'h2ad7d2bb; default: t_d = 32'heb86d391;
        endcase
    end

    assign x_d = a_q + f_d + blk_q[{g_d, 5'd0} +: 32] + t_d;
    assign b_d = b_q + rotl(x_d, s_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 6'd0;
            blk_q   <= '0;
            chain_q <= '0;
            dig_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    blk_q   <= block_in;
                    chain_q <= chain_src;
                    {a_q, b_q, c_q, d_q} <= chain_src;
                    i_q     <= 6'd0;
                    busy_q  <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q <= d_q;
                    b_q <= b_d;
                    c_q <= b_q;
                    d_q <= c_q;
                    i_q <= i_q + 6'd1;
                    if (i_q == 6'd63) state_q <= FIN;
                end
                FIN: begin
                    dig_q   <= {chain_q[127:96] + a_q, chain_q[95:64] + b_q,
                                chain_q[63:32]  + c_q, chain_q[31:0]  + d_q};
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign digest_out = dig_q;
endmodule

// File: tb/tb_md5_compress.sv
// tb_md5_compress: directed, table-driven bench for md5_compress using
// known MD5 digests of short messages, plus sequences for a mid-run start,
// a mid-run reset and back-to-back blocks with start held high.
module tb_md5_compress;
    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [511:0] block_in = '0;
`ifdef MD5_CHAIN_IN_EN
    logic [127:0] chain_in = IV;
`endif
    logic         busy, done;
    logic [127:0] digest_out;

    md5_compress dut (
        .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
`ifdef MD5_CHAIN_IN_EN
        .chain_in(chain_in),
`endif
        .busy(busy), .done(done), .digest_out(digest_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [511:0] blk;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[3];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done is seen; -1 when the bound expires.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < limit);
        if (!done) n = -1;
    endtask

`ifdef MD5_CHAIN_IN_EN
    // Independent software MD5 compression, constants derived from sin().
    function automatic logic [127:0] md5_ref(input logic [127:0] ch, input logic [511:0] blk);
        int sh[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
        logic [31:0] a, b, c, d, f, x, t, tmp;
        int g, s;
        real v;
        {a, b, c, d} = ch;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (b & d) | (c & ~d); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            v = $sin(real'(i + 1));
            if (v < 0.0) v = -v;
            t = 32'(longint'($floor(v * 4294967296.0)));
            s = sh[(i / 16) * 4 + (i % 4)];
            x = a + f + blk[g*32 +: 32] + t;
            tmp = d; d = c; c = b;
            b = b + ((x << s) | (x >> (32 - s)));
            a = tmp;
        end
        return {ch[127:96] + a, ch[95:64] + b, ch[63:32] + c, ch[31:0] + d};
    endfunction
`endif

    task automatic run_block(input vec_t v);
        int n;
        block_in = v.blk;
`ifdef MD5_CHAIN_IN_EN
        chain_in = IV;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check({v.name, " busy after accept"}, busy, 1);
        block_in = ~v.blk;  // inputs are don't-care once latched
`ifdef MD5_CHAIN_IN_EN
        chain_in = ~IV;
`endif
        wait_done(100, n);
        check({v.name, " latency"}, n, 65);
        check({v.name, " busy low at done"}, busy, 0);
        check({v.name, " digest"}, digest_out, v.exp);
        tick();
        check({v.name, " done one cycle"}, done, 0);
        check({v.name, " digest held"}, digest_out, v.exp);
    endtask

    initial begin
        int n, ndone, de;
        logic [127:0] dig, exp2;
        logic [511:0] b;

        b = '0; b[31:0] = 32'h00000080;
        vecs[0] = '{"empty", b, {32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec}};
        b = '0; b[31:0] = 32'h80636261; b[14*32 +: 32] = 32'h00000018;
        vecs[1] = '{"abc", b, {32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128}};
        b = '0; b[31:0] = 32'h00008061; b[14*32 +: 32] = 32'h00000008;
        vecs[2] = '{"a", b, {32'hb975c10c, 32'ha8b6f1c0, 32'he299c331, 32'h61267769}};

        // reset state
        tick(); tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset digest", digest_out, 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 3; k++) run_block(vecs[k]);

        // start mid-run with a different block is ignored
        block_in = vecs[0].blk;
`ifdef MD5_CHAIN_IN_EN
        chain_in = IV;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; de = 0; dig = '0;
        for (int e = 1; e <= 75; e++) begin
            if (e == 11) begin start = 1'b1; block_in = vecs[1].blk; end
            else start = 1'b0;
            tick();
            if (done) begin ndone++; de = e; dig = digest_out; end
        end
        start = 1'b0;
        check("midstart done count", ndone, 1);
        check("midstart done edge", de, 65);
        check("midstart digest", dig, vecs[0].exp);

        // reset during RUN aborts without a done pulse
        block_in = vecs[0].blk;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 30; e++) tick();
        rst_n = 1'b0;
        #1;
        ndone = 0;
        check("midreset busy", busy, 0);
        check("midreset digest", digest_out, 0);
        for (int e = 0; e < 4; e++) begin
            tick();
            if (done || busy || digest_out != 0) ndone++;
        end
        check("outputs quiet in reset", ndone, 0);
        rst_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (done) ndone++;
        end
        check("no done after release", ndone, 0);
        run_block(vecs[1]);

        // start held high: back-to-back blocks 66 cycles apart
        block_in = vecs[0].blk;
`ifdef MD5_CHAIN_IN_EN
        chain_in = IV;
`endif
        start = 1'b1;
        tick();
        wait_done(100, n);
        check("b2b first latency", n, 65);
        check("b2b first digest", digest_out, vecs[0].exp);
        block_in = vecs[1].blk;
`ifdef MD5_CHAIN_IN_EN
        chain_in = digest_out;
        exp2 = md5_ref(vecs[0].exp, vecs[1].blk);
`else
        exp2 = vecs[1].exp;
`endif
        wait_done(100, n);
        start = 1'b0;
        check("b2b spacing", n, 66);
        check("b2b second digest", digest_out, exp2);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/md5_compress.md
MD5_COMPRESS -- requirements
Module: md5_compress

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to compress block_in; sampled only in IDLE.
REQ-005 block_in  input  512  message block; word Mk = block_in[32k+31:32k], k=0..15, words little-endian as MD5 defines.
REQ-006 chain_in  input  128  incoming chaining value {A,B,C,D} = {[127:96],[95:64],[63:32],[31:0]}; present only when MD5_CHAIN_IN_EN is defined.
REQ-007 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-008 done  output  1  one-cycle pulse; digest_out valid.
REQ-009 digest_out  output  128  updated chaining value {A,B,C,D}, same packing as chain_in; held until the next done.

Function
REQ-010 The block SHALL have states IDLE, RUN, FIN; IDLE->RUN on start; RUN->FIN after step 63; FIN->IDLE unconditionally.
REQ-011 On the edge accepting start, the block SHALL latch block_in and the chaining value into internal registers, load working registers A,B,C,D from the chaining value, and clear step counter i to 0.
REQ-012 Each RUN edge SHALL execute exactly one MD5 step i: F = f_r(B,C,D); X = A + F + M[g] + T[i] (mod 2^32); A<=D, B<=B+rotl(X,s[i]), C<=B, D<=C; i<=i+1.
REQ-013 Round r = i[5:4]; f: r0 (B&C)|(~B&D); r1 (B&D)|(C&~D); r2 B^C^D; r3 C^(B|~D).
REQ-014 Message index g: r0 i; r1 (5i+1) mod 16; r2 (3i+5) mod 16; r3 7i mod 16.
REQ-015 Shift s[i]: r0 {7,12,17,22}; r1 {5,9,14,20}; r2 {4,11,16,23}; r3 {6,10,15,21}, indexed by i[1:0].
REQ-016 T[i] SHALL be the 64 RFC 1321 constants floor(2^32*|sin(i+1)|), held in an internal case table.
REQ-017 The FIN edge SHALL register digest_out = {chainA+A, chainB+B, chainC+C, chainD+D}, each add mod 2^32, and assert done.
REQ-018 Latency: if start is accepted at edge E0, done SHALL be high exactly for the cycle following edge E65; busy falls on the same edge done rises.
REQ-019 start while busy or during the done cycle SHALL be ignored; start may be accepted on the edge that ends the done cycle (back-to-back blocks, 66-cycle throughput).
REQ-020 block_in and chain_in SHALL be don't-care after the accepting edge; changes mid-run SHALL not affect the result.

Reset
REQ-021 While rst_n is low: state=IDLE, i=0, busy=0, done=0, digest_out=0, A..D and latched block/chain =0.
REQ-022 Reset asserted mid-RUN or in FIN SHALL abort the operation with no done pulse; the first start after release begins a fresh block.

Configuration
REQ-023 Macro MD5_CHAIN_IN_EN defined: chain_in port exists and is latched per REQ-011.
REQ-024 MD5_CHAIN_IN_EN undefined: no chain_in port; chaining value fixed to IV {67452301, efcdab89, 98badcfe, 10325476}; single-block hashing only.

Verification
REQ-025 Empty message, M0=32'h00000080, others 0, IV chain -> digest_out = {d98c1dd4, 04b2008f, 980980e9, 7e42f8ec} (hex d41d8cd98f00b204e9800998ecf8427e), done 65 edges after accept.
REQ-026 "abc": M0=32'h80636261, M14=32'h00000018, others 0, IV -> {98500190, b04fd23c, 7d3f96d6, 727fe128}.
REQ-027 start pulsed at step 10 with different block_in -> ignored; result of REQ-025 unchanged, exactly one done.
REQ-028 Reset pulsed at step 30, then start with REQ-026 block -> no done before reset release; correct "abc" digest afterward, all outputs 0 during reset.
REQ-029 start held high continuously with two blocks -> done pulses 66 cycles apart, both digests correct; with MD5_CHAIN_IN_EN, chain_in = first digest yields correct two-block digest vs software model.
